down_counter_4bit_ld: RTL

Loadable 4-bit down counter, the decrementing counterpart of the team's free-running up counter. It adds asynchronous reset, count enable, parallel load with a reload register, and a terminal-count pulse. It runs in periodic (auto-reload) or one-shot mode, and serves as a tick divider or interval timer beside the up-count logic in the same clock domain.

---
 rtl/down_counter_4bit_ld_if.sv | 34 +++
 rtl/down_counter_4bit_ld.sv | 78 +++++++
 2 files changed

// File: rtl/down_counter_4bit_ld_if.sv
// Control/status bundle for the loadable down counter.
// The master side drives enable, load and mode; the slave side returns
// the registered count, the terminal-count pulse and the armed flag.
interface down_counter_4bit_ld_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             periodic;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             running;

   modport master (
      output en,
      output load,
      output load_val,
      output periodic,
      input  count,
      input  tc,
      input  running
   );

   modport slave (
      input  en,
      input  load,
      input  load_val,
      input  periodic,
      output count,
      output tc,
      output running
   );
endinterface

// File: rtl/down_counter_4bit_ld.sv
// Loadable down counter with reload register, count enable and a
// one-cycle terminal-count pulse. Periodic mode reloads after reaching
// zero; one-shot mode disarms on the 1->0 step. The counter never wraps
// below zero: the step after zero is either a reload or a stop.
module down_counter_4bit_ld #(
   parameter int               WIDTH   = 4,
   parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b1}}
) (
   input logic                     clk,
   input logic                     rst,
   down_counter_4bit_ld_if.slave   bus
);

   logic [WIDTH-1:0] count_reg;
   logic [WIDTH-1:0] reload_reg;
   logic             running_reg;
   logic             tc_reg;

   logic [WIDTH-1:0] count_next;
   logic [WIDTH-1:0] reload_next;
   logic             running_next;
   logic             tc_next;

   // Next-state decode: load beats counting; tc is a pulse so it defaults low.
   always_comb begin
      count_next   = count_reg;
      reload_next  = reload_reg;
      running_next = running_reg;
      tc_next      = 1'b0;
      if (bus.load) begin
         // Restart from the new value; any pending terminal step is dropped.
         count_next   = bus.load_val;
         reload_next  = bus.load_val;
         running_next = (bus.load_val != {WIDTH{1'b0}});
      end else if (bus.en && running_reg) begin
         if (count_reg > {{(WIDTH-1){1'b0}}, 1'b1}) begin
            count_next = count_reg - {{(WIDTH-1){1'b0}}, 1'b1};
         end else if (count_reg == {{(WIDTH-1){1'b0}}, 1'b1}) begin
            // The mode is sampled only here, on the 1->0 step.
            count_next   = {WIDTH{1'b0}};
            tc_next      = 1'b1;
            running_next = bus.periodic;
         end else begin
            // Sitting at zero while armed: only reachable in periodic mode.
            count_next = reload_reg;
            if (reload_reg == {WIDTH{1'b0}}) begin
               running_next = 1'b0;
            end else begin
               running_next = 1'b1;
            end
         end
      end else begin
         count_next   = count_reg;
         reload_next  = reload_reg;
         running_next = running_reg;
      end
   end

   // State register: async reset arms the counter at RST_VAL.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg   <= RST_VAL;
         reload_reg  <= RST_VAL;
         running_reg <= 1'b1;
         tc_reg      <= 1'b0;
      end else begin
         count_reg   <= count_next;
         reload_reg  <= reload_next;
         running_reg <= running_next;
         tc_reg      <= tc_next;
      end
   end

   assign bus.count   = count_reg;
   assign bus.tc      = tc_reg;
   assign bus.running = running_reg;

endmodule
